// File: rtl/ccd_clock_sequencer_if.sv
// Control/config and clock-output bundle for ccd_clock_sequencer.
// Optional CCD_BINNING_EN adds the bin2 request bit.
interface ccd_clock_sequencer_if #(
  parameter int CNT_W = 8,
  parameter int PIX_W = 12
);
  logic             start;
  logic [CNT_W-1:0] integ_len;
  logic [CNT_W-1:0] half_per;
  logic [PIX_W-1:0] n_pix;
`ifdef CCD_BINNING_EN
  logic             bin2;
`endif
  logic             phi_p;
  logic             phi_l1;
  logic             phi_l2;
  logic             phi_r;
  logic             sample;
  logic             busy;
  logic             done;
  logic [PIX_W-1:0] pix_cnt;

  modport master (
`ifdef CCD_BINNING_EN
    output bin2,
`endif
    output start, integ_len, half_per, n_pix,
    input  phi_p, phi_l1, phi_l2, phi_r, sample, busy, done, pix_cnt
  );

  modport slave (
`ifdef CCD_BINNING_EN
    input  bin2,
`endif
    input  start, integ_len, half_per, n_pix,
    output phi_p, phi_l1, phi_l2, phi_r, sample, busy, done, pix_cnt
  );
endinterface

// File: rtl/ccd_clock_sequencer.sv
// CCD frame clock sequencer: INTEG -> TRANSFER -> SHIFT (two-phase) -> DONE.
// Optional macro CCD_BINNING_EN enables 2x binning of reset/sample strobes.
module ccd_clock_sequencer #(
  parameter int CNT_W = 8,
  parameter int PIX_W = 12
) (
  input  logic clk,
  input  logic rst,
  ccd_clock_sequencer_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INTEG = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [PIX_W-1:0] PIX_ONE = 1;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] integ_q, integ_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [PIX_W-1:0] npix_q, npix_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             phb_q, phb_d;
`ifdef CCD_BINNING_EN
  logic             bin2_q, bin2_d;
`endif

  logic integ_last, half_last, pix_last, r_en, s_en;
  logic phi_p, phi_l1, phi_l2, phi_r, sample, done;

  // Zero-length settings behave as one cycle: cnt never leaves 0.
  assign integ_last = (integ_q == '0) || (cnt_q == integ_q - CNT_ONE);
  assign half_last  = (half_q  == '0) || (cnt_q == half_q  - CNT_ONE);
  assign pix_last   = (pix_q == npix_q - PIX_ONE);

`ifdef CCD_BINNING_EN
  // Pairs of pixels share one reset (first) and one sample (second or last).
  assign r_en = !bin2_q || !pix_q[0];
  assign s_en = !bin2_q ||  pix_q[0] || pix_last;
`else
  assign r_en = 1'b1;
  assign s_en = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    integ_d = integ_q;
    half_d  = half_q;
    npix_d  = npix_q;
    pix_d   = pix_q;
    phb_d   = phb_q;
`ifdef CCD_BINNING_EN
    bin2_d  = bin2_q;
`endif
    phi_p   = 1'b0;
    phi_l1  = 1'b0;
    phi_l2  = 1'b0;
    phi_r   = 1'b0;
    sample  = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          integ_d = bus.integ_len;
          half_d  = bus.half_per;
          npix_d  = bus.n_pix;
`ifdef CCD_BINNING_EN
          bin2_d  = bus.bin2;
`endif
          pix_d   = '0;
          cnt_d   = '0;
          phb_d   = 1'b0;
          state_d = S_INTEG;
        end
      end
      S_INTEG: begin
        phi_p = 1'b1;
        if (integ_last) begin
          cnt_d   = '0;
          state_d = S_XFER;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_XFER: begin
        phi_l1 = 1'b1;
        if (half_last) begin
          cnt_d   = '0;
          phb_d   = 1'b0;
          state_d = (npix_q == '0) ? S_DONE : S_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_SHIFT: begin
        if (!phb_q) begin
          phi_l1 = 1'b1;
          phi_r  = (cnt_q == '0) && r_en;
          if (half_last) begin
            cnt_d = '0;
            phb_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          phi_l2 = 1'b1;
          if (half_last) begin
            sample = s_en;
            cnt_d  = '0;
            phb_d  = 1'b0;
            pix_d  = pix_q + PIX_ONE;
            if (pix_last) state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      integ_q <= '0;
      half_q  <= '0;
      npix_q  <= '0;
      pix_q   <= '0;
      phb_q   <= 1'b0;
`ifdef CCD_BINNING_EN
      bin2_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      integ_q <= integ_d;
      half_q  <= half_d;
      npix_q  <= npix_d;
      pix_q   <= pix_d;
      phb_q   <= phb_d;
`ifdef CCD_BINNING_EN
      bin2_q  <= bin2_d;
`endif
    end
  end

  assign bus.phi_p   = phi_p;
  assign bus.phi_l1  = phi_l1;
  assign bus.phi_l2  = phi_l2;
  assign bus.phi_r   = phi_r;
  assign bus.sample  = sample;
  assign bus.done    = done;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.pix_cnt = pix_q;
endmodule

// File: tb/tb_ccd_clock_sequencer.sv
// Self-checking bench: per-cycle comparison against a timeline model built from
// the frame rules (integration, transfer, two-phase shift, done).
module tb_ccd_clock_sequencer;
  localparam int CNT_W = 8;
  localparam int PIX_W = 12;

  typedef struct packed {
    logic busy, done, p, l1, l2, r, s;
    logic [PIX_W-1:0] pc;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;
  obs_t exp_q[$];

  ccd_clock_sequencer_if #(.CNT_W(CNT_W), .PIX_W(PIX_W)) bus ();

  ccd_clock_sequencer #(.CNT_W(CNT_W), .PIX_W(PIX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample_dut();
    obs_t o;
    o.busy = bus.busy;  o.done = bus.done;  o.p = bus.phi_p;
    o.l1 = bus.phi_l1;  o.l2 = bus.phi_l2;  o.r = bus.phi_r;
    o.s = bus.sample;   o.pc = bus.pix_cnt;
    return o;
  endfunction

  // Expected per-cycle timeline of one frame, starting the cycle after start.
  function automatic void build_frame(input int il, input int hp, input int np, input bit bin);
    obs_t e;
    int ie = (il == 0) ? 1 : il;
    int he = (hp == 0) ? 1 : hp;
    bit bn = 1'b0;
`ifdef CCD_BINNING_EN
    bn = bin;
`else
    if (bin) bn = 1'b0;
`endif
    exp_q.delete();
    for (int i = 0; i < ie; i++) begin
      e = '0; e.busy = 1; e.p = 1; exp_q.push_back(e);
    end
    for (int i = 0; i < he; i++) begin
      e = '0; e.busy = 1; e.l1 = 1; exp_q.push_back(e);
    end
    for (int k = 0; k < np; k++) begin
      for (int i = 0; i < he; i++) begin
        e = '0; e.busy = 1; e.l1 = 1; e.pc = PIX_W'(k);
        e.r = (i == 0) && (!bn || (k % 2 == 0));
        exp_q.push_back(e);
      end
      for (int i = 0; i < he; i++) begin
        e = '0; e.busy = 1; e.l2 = 1; e.pc = PIX_W'(k);
        e.s = (i == he - 1) && (!bn || (k % 2 == 1) || (k == np - 1));
        exp_q.push_back(e);
      end
    end
    e = '0; e.busy = 1; e.done = 1; e.pc = PIX_W'(np); exp_q.push_back(e);
    e = '0; e.pc = PIX_W'(np); exp_q.push_back(e);
  endfunction

  // Runs one frame; with noise, start and config inputs toggle mid-frame.
  task automatic do_frame(input int il, input int hp, input int np, input bit bin,
                          input bit noise, output int n_busy, output int n_samp, output int n_r);
    obs_t o;
    n_busy = 0; n_samp = 0; n_r = 0;
    build_frame(il, hp, np, bin);
    @(negedge clk);
    bus.integ_len = CNT_W'(il);
    bus.half_per  = CNT_W'(hp);
    bus.n_pix     = PIX_W'(np);
`ifdef CCD_BINNING_EN
    bus.bin2 = bin;
`endif
    bus.start = 1'b1;
    for (int j = 0; j < exp_q.size(); j++) begin
      @(negedge clk);
      o = sample_dut();
      total++;
      if (o !== exp_q[j]) begin
        bad++;
        $display("FAIL frame(il=%0d hp=%0d np=%0d) cyc %0d: got %h need %h",
                 il, hp, np, j, o, exp_q[j]);
      end
      total++;
      if (o.l1 & o.l2) begin
        bad++;
        $display("FAIL phase_overlap cyc %0d: got l1=1 l2=1 need not both", j);
      end
      n_busy += int'(o.busy);
      n_samp += int'(o.s);
      n_r    += int'(o.r);
      if (noise && j < exp_q.size() - 1) begin
        bus.start     = 1'($urandom);
        bus.integ_len = CNT_W'($urandom);
        bus.half_per  = CNT_W'($urandom);
        bus.n_pix     = PIX_W'($urandom);
`ifdef CCD_BINNING_EN
        bus.bin2 = 1'($urandom);
`endif
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    #2;
    o = sample_dut();
    total++;
    if (o !== obs_t'(0)) begin
      bad++; $display("FAIL reset_state: got %h need 0", o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset: got busy=%b need 0", bus.busy);
    end
  endtask

  task automatic test_basic();
    int nb, ns, nr;
    do_frame(4, 2, 3, 1'b0, 1'b0, nb, ns, nr);
    total++;
    if (nb != 19) begin bad++; $display("FAIL basic_busy_len: got %0d need 19", nb); end
    total++;
    if (ns != 3) begin bad++; $display("FAIL basic_samples: got %0d need 3", ns); end
    total++;
    if (nr != 3) begin bad++; $display("FAIL basic_phi_r: got %0d need 3", nr); end
  endtask

  task automatic test_zero_lengths();
    int nb, ns, nr;
    do_frame(0, 0, 2, 1'b0, 1'b0, nb, ns, nr);
    total++;
    if (nb != 1 + 1 + 4 + 1) begin bad++; $display("FAIL zero_len_busy: got %0d need 7", nb); end
    total++;
    if (ns != 2) begin bad++; $display("FAIL zero_len_samples: got %0d need 2", ns); end
  endtask

  task automatic test_no_pixels();
    int nb, ns, nr;
    do_frame(3, 2, 0, 1'b0, 1'b0, nb, ns, nr);
    total++;
    if (ns != 0 || nr != 0) begin
      bad++; $display("FAIL no_pix_strobes: got s=%0d r=%0d need 0/0", ns, nr);
    end
    total++;
    if (nb != 3 + 2 + 1) begin bad++; $display("FAIL no_pix_busy: got %0d need 6", nb); end
  endtask

  task automatic test_mid_reset();
    int nb, ns, nr, cyc;
    bit seen_done;
    @(negedge clk);
    bus.integ_len = 8'd1; bus.half_per = 8'd1; bus.n_pix = 12'd8;
`ifdef CCD_BINNING_EN
    bus.bin2 = 1'b0;
`endif
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (!(bus.pix_cnt == 12'd5 && bus.phi_l1) && cyc < 100) begin
      @(negedge clk); cyc++;
    end
    total++;
    if (cyc >= 100) begin bad++; $display("FAIL mid_reset_reach: got timeout need pix_cnt=5"); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (sample_dut() !== obs_t'(0)) begin
      bad++; $display("FAIL mid_reset_outputs: got %h need 0", sample_dut());
    end
    seen_done = 1'b0;
    repeat (2) begin @(negedge clk); seen_done |= bus.done; end
    rst = 1'b0;
    repeat (4) begin @(negedge clk); seen_done |= bus.done | bus.busy; end
    total++;
    if (seen_done) begin bad++; $display("FAIL mid_reset_quiet: got activity need none"); end
    do_frame(1, 1, 3, 1'b0, 1'b0, nb, ns, nr);
    total++;
    if (ns != 3) begin bad++; $display("FAIL restart_samples: got %0d need 3", ns); end
  endtask

  task automatic test_back_to_back();
    int nb, ns, nr;
    do_frame(4, 2, 3, 1'b0, 1'b1, nb, ns, nr);
    total++;
    if (nb != 19) begin bad++; $display("FAIL noisy_busy_len: got %0d need 19", nb); end
    do_frame(2, 3, 4, 1'b0, 1'b1, nb, ns, nr);
    total++;
    if (ns != 4) begin bad++; $display("FAIL noisy_samples: got %0d need 4", ns); end
  endtask

  task automatic test_binning();
    int nb, ns, nr;
`ifdef CCD_BINNING_EN
    do_frame(2, 1, 5, 1'b1, 1'b0, nb, ns, nr);
    total++;
    if (ns != 3) begin bad++; $display("FAIL bin_samples: got %0d need 3", ns); end
    total++;
    if (nr != 3) begin bad++; $display("FAIL bin_phi_r: got %0d need 3", nr); end
`else
    do_frame(2, 1, 5, 1'b0, 1'b0, nb, ns, nr);
    total++;
    if (ns != 5) begin bad++; $display("FAIL nobin_samples: got %0d need 5", ns); end
    total++;
    if (nr != 5) begin bad++; $display("FAIL nobin_phi_r: got %0d need 5", nr); end
`endif
    total++;
    if (bus.pix_cnt !== 12'd5) begin
      bad++; $display("FAIL bin_pix_cnt: got %0d need 5", bus.pix_cnt);
    end
  endtask

  task automatic test_random();
    int nb, ns, nr;
    for (int f = 0; f < 20; f++) begin
      do_frame($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 6),
               1'($urandom), 1'($urandom), nb, ns, nr);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.integ_len = '0; bus.half_per = '0; bus.n_pix = '0;
`ifdef CCD_BINNING_EN
    bus.bin2 = 1'b0;
`endif
    test_reset();
    test_basic();
    test_zero_lengths();
    test_no_pixels();
    test_mid_reset();
    test_back_to_back();
    test_binning();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ccd_clock_sequencer.md
CCD_CLOCK_SEQUENCER -- requirements
Module: ccd_clock_sequencer

Interface
REQ-001 Parameter CNT_W, default 8: width of the phase-length counter and of integ_len/half_per.
REQ-002 Parameter PIX_W, default 12: width of pixel count input/output.
REQ-003 clk  input  1  single system clock; all state advances on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a frame; sampled only in IDLE.
REQ-006 integ_len  input  CNT_W  integration length in clk cycles; 0 treated as 1.
REQ-007 half_per  input  CNT_W  half pixel period in clk cycles; 0 treated as 1.
REQ-008 n_pix  input  PIX_W  pixels per line; 0 means frame ends after TRANSFER with no SHIFT.
REQ-009 phi_p  output  1  photogate/integration clock.
REQ-010 phi_l1, phi_l2  output  1 each  two-phase shift-register clocks.
REQ-011 phi_r  output  1  output-node reset gate.
REQ-012 sample  output  1  one-cycle ADC sample strobe per output pixel.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse at end of frame.
REQ-015 pix_cnt  output  PIX_W  pixels shifted in the current frame.

Function
REQ-016 FSM states SHALL be IDLE, INTEG, TRANSFER, SHIFT, DONE.
REQ-017 IDLE with start=1 SHALL latch integ_len, half_per, n_pix into internal registers and go to INTEG next cycle; later input changes SHALL not affect the running frame.
REQ-018 INTEG: phi_p=1 for exactly max(integ_len,1) cycles, then TRANSFER.
REQ-019 TRANSFER: phi_p=0, phi_l1=1, phi_l2=0 for exactly max(half_per,1) cycles, then SHIFT (or DONE if n_pix=0).
REQ-020 SHIFT pixel period = 2*max(half_per,1) cycles: phase A phi_l1=1/phi_l2=0, phase B phi_l1=0/phi_l2=1, each max(half_per,1) cycles.
REQ-021 phi_l1 and phi_l2 SHALL never be high in the same cycle.
REQ-022 phi_r SHALL be high only in the first cycle of phase A of each output pixel.
REQ-023 sample SHALL pulse in the last cycle of phase B of each output pixel.
REQ-024 pix_cnt SHALL increment at end of each pixel period, clear on frame start; SHIFT exits to DONE when pix_cnt reaches n_pix.
REQ-025 DONE lasts one cycle with done=1, then IDLE; start in DONE or any busy state SHALL be ignored.
REQ-026 Outside INTEG/TRANSFER/SHIFT, phi_p, phi_l1, phi_l2, phi_r, sample SHALL be 0.
REQ-027 Counters SHALL be CNT_W/PIX_W wide without wrap; comparisons are against latched values.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, all outputs 0, pix_cnt=0, counters 0, including mid-frame; no done pulse.
REQ-029 After rst deasserts, first frame begins only on a new start.

Configuration
REQ-030 Macro CCD_BINNING_EN: when defined, input bin2 (1 bit, latched on start) enables 2x binning: phi_r and sample occur once per two pixel periods (phi_r on first pixel, sample on second), pix_cnt counts shifted pixels, odd n_pix ends with a final sample on the last pixel.
REQ-031 Without CCD_BINNING_EN, port bin2 SHALL not exist and every pixel gets phi_r and sample.

Verification
REQ-032 integ_len=4, half_per=2, n_pix=3, start -> phi_p high 4 cycles, TRANSFER 2 cycles, 3 sample pulses 4 cycles apart, done 1 cycle, busy high for 4+2+12+1=19 cycles.
REQ-033 half_per=0, integ_len=0, n_pix=2 -> behaves as 1/1: pixel period 2 cycles, 2 samples.
REQ-034 n_pix=0 -> no phi_r/sample, done directly after TRANSFER.
REQ-035 rst asserted mid-SHIFT at pix_cnt=5 -> all outputs 0 same cycle, no done, restart on next start with pix_cnt from 0.
REQ-036 start pulsed while busy, and inputs changed mid-frame -> frame timing unchanged; assertion check phi_l1&phi_l2 never 1.
REQ-037 With CCD_BINNING_EN, bin2=1, n_pix=5, half_per=1 -> 3 samples (pixels 2,4,5), 3 phi_r pulses, pix_cnt ends at 5.
